dmem_responder: RTL

Data-memory responder for the core's split write/read data bus: the target end of the `dmem_*` ready/valid interface the core drives as initiator. It accepts byte-strobed writes and word reads into a word-addressed internal array, returns read data one cycle after acceptance, and can insert programmable wait states per channel. It sits beside the MMIO timer on the decoded non-MMIO path and serves as both the simulation data RAM and the synthesizable scratch RAM.

---
 rtl/dmem_responder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: target end of the core's split write/read data bus.
// Word-addressed RAM with byte-strobed writes and registered read data.
// Build option: define DMEM_WAIT_EN to enable the per-channel wait-state FSMs
// (RLAT/WLAT honoured). Without it, wvalid/rvalid are tied high.
module dmem_responder #(
  parameter int unsigned DEPTH = 16384,
  parameter logic [31:0] BASE  = 32'h0000_0000,
  parameter int unsigned RLAT  = 0,
  parameter int unsigned WLAT  = 0
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        wready,
  output logic        wvalid,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        rready,
  output logic        rvalid,
  input  logic [31:0] raddr,
  output logic        rresp,
  output logic [31:0] rdata,
  output logic        werr
);

  localparam int unsigned IW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  logic [31:0]   mem_r [DEPTH];
  logic [31:0]   woff_s;
  logic [31:0]   roff_s;
  logic          w_in_s;
  logic          r_in_s;
  logic [IW-1:0] widx_s;
  logic [IW-1:0] ridx_s;
  logic          w_acc_s;
  logic          r_acc_s;
  logic          unused_s;

  // Address decode: offset from BASE, range test in 33 bits so DEPTH*4 never wraps
  assign woff_s   = waddr - BASE;
  assign roff_s   = raddr - BASE;
  assign w_in_s   = ({1'b0, woff_s} < SPAN);
  assign r_in_s   = ({1'b0, roff_s} < SPAN);
  assign widx_s   = woff_s[IW+1:2];
  assign ridx_s   = roff_s[IW+1:2];
  assign unused_s = ^{woff_s[1:0], roff_s[1:0]};

  // Handshakes never complete while reset is asserted
  assign w_acc_s = wready && wvalid && !resetb;
  assign r_acc_s = rready && rvalid && !resetb;

`ifdef DMEM_WAIT_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} st_e;

  localparam logic [3:0] RLAT_C = 4'(RLAT);
  localparam logic [3:0] WLAT_C = 4'(WLAT);
  localparam logic       RL0_C  = (RLAT == 0);
  localparam logic       WL0_C  = (WLAT == 0);

  st_e        rd_st_r, rd_st_nxt_s, wr_st_r, wr_st_nxt_s;
  logic [3:0] rd_cnt_r, rd_cnt_nxt_s, wr_cnt_r, wr_cnt_nxt_s;

  // Read/write wait-state registers
  always_ff @(posedge clk) begin
    if (resetb) begin
      rd_st_r  <= ST_IDLE;
      rd_cnt_r <= 4'd0;
      wr_st_r  <= ST_IDLE;
      wr_cnt_r <= 4'd0;
    end else begin
      rd_st_r  <= rd_st_nxt_s;
      rd_cnt_r <= rd_cnt_nxt_s;
      wr_st_r  <= wr_st_nxt_s;
      wr_cnt_r <= wr_cnt_nxt_s;
    end
  end

  // Read next state: start countdown on a stalled request, abandon on withdrawal
  always_comb begin
    rd_st_nxt_s  = rd_st_r;
    rd_cnt_nxt_s = rd_cnt_r;
    case (rd_st_r)
      ST_IDLE: begin
        if (rready && !rvalid) begin
          rd_st_nxt_s  = ST_WAIT;
          rd_cnt_nxt_s = RLAT_C - 4'd1;
        end else begin
          rd_st_nxt_s  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!rready || rvalid) begin
          rd_st_nxt_s  = ST_IDLE;
        end else begin
          rd_cnt_nxt_s = rd_cnt_r - 4'd1;
        end
      end
      default: rd_st_nxt_s = ST_IDLE;
    endcase
  end

  // Read ready: immediate when no wait states, otherwise when countdown expires
  always_comb begin
    case (rd_st_r)
      ST_IDLE: rvalid = RL0_C;
      ST_WAIT: rvalid = (rd_cnt_r == 4'd0);
      default: rvalid = 1'b0;
    endcase
  end

  // Write next state: mirror of the read channel
  always_comb begin
    wr_st_nxt_s  = wr_st_r;
    wr_cnt_nxt_s = wr_cnt_r;
    case (wr_st_r)
      ST_IDLE: begin
        if (wready && !wvalid) begin
          wr_st_nxt_s  = ST_WAIT;
          wr_cnt_nxt_s = WLAT_C - 4'd1;
        end else begin
          wr_st_nxt_s  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!wready || wvalid) begin
          wr_st_nxt_s  = ST_IDLE;
        end else begin
          wr_cnt_nxt_s = wr_cnt_r - 4'd1;
        end
      end
      default: wr_st_nxt_s = ST_IDLE;
    endcase
  end

  // Write ready: immediate when no wait states, otherwise when countdown expires
  always_comb begin
    case (wr_st_r)
      ST_IDLE: wvalid = WL0_C;
      ST_WAIT: wvalid = (wr_cnt_r == 4'd0);
      default: wvalid = 1'b0;
    endcase
  end
`else
  logic unused_lat_s;

  assign rvalid       = 1'b1;
  assign wvalid       = 1'b1;
  assign unused_lat_s = ^{4'(RLAT), 4'(WLAT)};
`endif

  // Read response: registered data/status of the last accepted read
  always_ff @(posedge clk) begin
    if (resetb) begin
      rdata <= 32'd0;
      rresp <= 1'b1;
    end else if (r_acc_s) begin
      rresp <= r_in_s;
      rdata <= r_in_s ? mem_r[ridx_s] : 32'd0;
    end
  end

  // Sticky decode-error flag for writes outside the array
  always_ff @(posedge clk) begin
    if (resetb) begin
      werr <= 1'b0;
    end else if (w_acc_s && !w_in_s) begin
      werr <= 1'b1;
    end
  end

  // Array update: byte lanes selected by wstrb; contents are not reset
  always_ff @(posedge clk) begin
    if (w_acc_s && w_in_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem_r[widx_s][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
